// File: rtl/core_mem_port.sv
// Data-side memory port: local dual-port RAM plus a posted remote-write buffer
// feeding a registered remote bus master; remote loads wait for the buffer to drain.

module dpsram #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 2048,
    parameter int AW         = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         addr_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [AW-1:0]         addr_b,
    input  logic                  we_b,
    input  logic [DATA_WIDTH-1:0] d_b,
    output logic [DATA_WIDTH-1:0] q_b
);
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
        if (we_b) mem[addr_b] <= d_b;
    end
endmodule

module core_mem_port #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_SIZE   = 2048,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] iaddr,
    output logic [DATA_WIDTH-1:0] idata,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] ddata_out,
    input  logic                  dwrite_en,
    input  logic                  dread_en,
    output logic [DATA_WIDTH-1:0] ddata_in,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] remote_addr,
    output logic                  remote_wren,
    output logic                  remote_rden,
    output logic [DATA_WIDTH-1:0] remote_write_val,
    input  logic                  remote_ready,
    input  logic [DATA_WIDTH-1:0] remote_read_val,
    output logic                  wbuf_empty
);
    localparam int LMEM_ADDR_WIDTH = $clog2(MEM_SIZE);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] fifo_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [WBUF_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr, rd_ptr_inc;
    logic [CW-1:0]         count;
    logic                  read_done, done_nx;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic                  wren_nx, rden_nx;
    logic                  sel_local_r;
    logic                  local_sel, is_wr, is_rd, wr_remote, rd_remote;
    logic                  full, accept, push, pop;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  unused_iaddr;

    assign local_sel  = (daddr[ADDR_WIDTH-1:LMEM_ADDR_WIDTH] == '0);
    assign is_wr      = dwrite_en;
    assign is_rd      = dread_en && !dwrite_en;
    assign wr_remote  = is_wr && !local_sel;
    assign rd_remote  = is_rd && !local_sel;
    assign full       = (count == CW'(WBUF_DEPTH));
    // A full buffer stalls a remote store even when a pop lands on the same edge.
    assign stall      = (wr_remote && full) || (rd_remote && !read_done);
    assign accept     = (dwrite_en || dread_en) && !stall;
    assign push       = accept && wr_remote;
    assign rd_ptr_inc = rd_ptr + PW'(1);
    assign wbuf_empty = (count == '0) && (state != WRITE);
    assign ddata_in   = sel_local_r ? q_b : rdata_r;
    assign unused_iaddr = ^iaddr[ADDR_WIDTH-1:LMEM_ADDR_WIDTH];

    dpsram #(.DATA_WIDTH(DATA_WIDTH), .MEM_SIZE(MEM_SIZE)) u_mem (
        .clk    (clk),
        .addr_a (iaddr[LMEM_ADDR_WIDTH-1:0]),
        .q_a    (idata),
        .addr_b (daddr[LMEM_ADDR_WIDTH-1:0]),
        .we_b   (accept && is_wr && local_sel),
        .d_b    (ddata_out),
        .q_b    (q_b)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= daddr;
            fifo_data[wr_ptr] <= ddata_out;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = remote_addr;
        wdata_nx = remote_write_val;
        wren_nx  = remote_wren;
        rden_nx  = remote_rden;
        rdata_nx = rdata_r;
        done_nx  = read_done;
        pop      = 1'b0;
        if (accept && rd_remote) done_nx = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = WRITE;
                    addr_nx  = fifo_addr[rd_ptr];
                    wdata_nx = fifo_data[rd_ptr];
                    wren_nx  = 1'b1;
                end else if (rd_remote && !read_done) begin
                    state_nx = READ;
                    addr_nx  = daddr;
                    rden_nx  = 1'b1;
                end
            end
            WRITE: begin
                if (remote_ready) begin
                    pop = 1'b1;
                    if (count > CW'(1)) begin
                        addr_nx  = fifo_addr[rd_ptr_inc];
                        wdata_nx = fifo_data[rd_ptr_inc];
                    end else if (push) begin
                        // next head is being enqueued on this very edge
                        addr_nx  = daddr;
                        wdata_nx = ddata_out;
                    end else begin
                        wren_nx  = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            READ: begin
                if (remote_ready) begin
                    rdata_nx = remote_read_val;
                    done_nx  = 1'b1;
                    rden_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            remote_addr      <= '0;
            remote_write_val <= '0;
            remote_wren      <= 1'b0;
            remote_rden      <= 1'b0;
            rdata_r          <= '0;
            read_done        <= 1'b0;
            sel_local_r      <= 1'b1;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
        end else begin
            state            <= state_nx;
            remote_addr      <= addr_nx;
            remote_write_val <= wdata_nx;
            remote_wren      <= wren_nx;
            remote_rden      <= rden_nx;
            rdata_r          <= rdata_nx;
            read_done        <= done_nx;
            if (accept && is_rd) sel_local_r <= local_sel;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_port.sv
// Directed bench for core_mem_port: local path, posted remote writes, full
// buffer stall, read-after-write ordering, k=0 remote load and async reset.

module tb_core_mem_port;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] iaddr, daddr, ddata_out, remote_read_val;
    logic        dwrite_en, dread_en, remote_ready;
    logic [15:0] idata, ddata_in, remote_addr, remote_write_val;
    logic        stall, remote_wren, remote_rden, wbuf_empty;

    int total = 0;
    int bad   = 0;

    core_mem_port dut (
        .clk              (clk),
        .reset            (reset),
        .iaddr            (iaddr),
        .idata            (idata),
        .daddr            (daddr),
        .ddata_out        (ddata_out),
        .dwrite_en        (dwrite_en),
        .dread_en         (dread_en),
        .ddata_in         (ddata_in),
        .stall            (stall),
        .remote_addr      (remote_addr),
        .remote_wren      (remote_wren),
        .remote_rden      (remote_rden),
        .remote_write_val (remote_write_val),
        .remote_ready     (remote_ready),
        .remote_read_val  (remote_read_val),
        .wbuf_empty       (wbuf_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; iaddr = '0; daddr = '0; ddata_out = '0;
        dwrite_en = 1'b0; dread_en = 1'b0; remote_ready = 1'b0; remote_read_val = '0;
        tick(); tick();
        chk("rst_wren", remote_wren, 0);
        chk("rst_rden", remote_rden, 0);
        chk("rst_addr", remote_addr, 0);
        chk("rst_wval", remote_write_val, 0);
        chk("rst_empty", wbuf_empty, 1);
        chk("rst_stall", stall, 0);
        reset = 1'b0;
        tick();

        // local store then load
        daddr = 16'h0010; ddata_out = 16'h1234; dwrite_en = 1'b1; settle();
        chk("loc_st_stall", stall, 0);
        tick();
        dwrite_en = 1'b0; dread_en = 1'b1; settle();
        chk("loc_ld_stall", stall, 0);
        tick();
        dread_en = 1'b0; settle();
        chk("loc_ld_data", ddata_in, 16'h1234);
        chk("loc_wren", remote_wren, 0);
        chk("loc_rden", remote_rden, 0);

        // remote store, ready in the third strobe cycle
        tick();
        daddr = 16'h8000; ddata_out = 16'hBEEF; dwrite_en = 1'b1; settle();
        chk("rst1_stall", stall, 0);
        tick();
        dwrite_en = 1'b0; settle();
        chk("rst1_nempty", wbuf_empty, 0);
        chk("rst1_wren_lo", remote_wren, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst1_wren", remote_wren, 1);
            chk("rst1_addr", remote_addr, 16'h8000);
            chk("rst1_wval", remote_write_val, 16'hBEEF);
            if (i == 2) remote_ready = 1'b1;
            tick();
        end
        remote_ready = 1'b0; settle();
        chk("rst1_wren_off", remote_wren, 0);
        chk("rst1_empty", wbuf_empty, 1);

        // five stores into a depth-4 buffer with ready low
        tick();
        for (int i = 1; i <= 4; i++) begin
            daddr = 16'h8000 + 16'(i); ddata_out = 16'h1000 + 16'(i); dwrite_en = 1'b1; settle();
            chk("fill_stall", stall, 0);
            tick();
        end
        daddr = 16'h8005; ddata_out = 16'h1005; settle();
        chk("full_stall_a", stall, 1);
        chk("full_head_addr", remote_addr, 16'h8001);
        tick();
        chk("full_stall_b", stall, 1);
        remote_ready = 1'b1; settle();
        chk("full_stall_pop", stall, 1);
        tick();
        remote_ready = 1'b0; settle();
        chk("full_accept", stall, 0);
        chk("full_head2", remote_addr, 16'h8002);
        tick();
        dwrite_en = 1'b0; remote_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            settle();
            chk("order_wren", remote_wren, 1);
            chk("order_addr", remote_addr, 16'h8000 + 16'(i));
            chk("order_wval", remote_write_val, 16'h1000 + 16'(i));
            tick();
        end
        remote_ready = 1'b0; settle();
        chk("order_done", remote_wren, 0);
        chk("order_empty", wbuf_empty, 1);

        // two buffered writes, then remote load 0x9000
        tick();
        daddr = 16'h8100; ddata_out = 16'h1111; dwrite_en = 1'b1; tick();
        daddr = 16'h8101; ddata_out = 16'h2222; tick();
        dwrite_en = 1'b0; dread_en = 1'b1; daddr = 16'h9000; settle();
        chk("raw_stall0", stall, 1);
        chk("raw_wA", remote_addr, 16'h8100);
        chk("raw_rden0", remote_rden, 0);
        remote_ready = 1'b1; tick();
        chk("raw_stall1", stall, 1);
        chk("raw_wB", remote_addr, 16'h8101);
        chk("raw_rden1", remote_rden, 0);
        tick();
        remote_ready = 1'b0; settle();
        chk("raw_stall2", stall, 1);
        chk("raw_wren2", remote_wren, 0);
        chk("raw_rden2", remote_rden, 0);
        chk("raw_empty2", wbuf_empty, 1);
        tick();
        chk("raw_rden3", remote_rden, 1);
        chk("raw_raddr", remote_addr, 16'h9000);
        chk("raw_stall3", stall, 1);
        remote_ready = 1'b1; remote_read_val = 16'hCAFE; tick();
        remote_ready = 1'b0; remote_read_val = 16'h0000; settle();
        chk("raw_stall4", stall, 0);
        chk("raw_rden4", remote_rden, 0);
        tick();
        dread_en = 1'b0; settle();
        chk("raw_data", ddata_in, 16'hCAFE);

        // remote load with k=0, then a local load right after
        tick();
        dread_en = 1'b1; daddr = 16'hA000; settle();
        chk("k0_stall0", stall, 1);
        chk("k0_rden0", remote_rden, 0);
        tick();
        chk("k0_rden1", remote_rden, 1);
        chk("k0_stall1", stall, 1);
        remote_ready = 1'b1; remote_read_val = 16'h5A5A; tick();
        remote_ready = 1'b0; remote_read_val = 16'h0000; settle();
        chk("k0_stall2", stall, 0);
        tick();
        daddr = 16'h0010; settle();
        chk("k0_data", ddata_in, 16'h5A5A);
        chk("k0_loc_stall", stall, 0);
        tick();
        dread_en = 1'b0; settle();
        chk("k0_loc_data", ddata_in, 16'h1234);

        // reset while three writes are queued
        tick();
        for (int i = 0; i < 3; i++) begin
            daddr = 16'h8200 + 16'(i); ddata_out = 16'h3000 + 16'(i); dwrite_en = 1'b1; tick();
        end
        dwrite_en = 1'b0; settle();
        chk("rq_wren", remote_wren, 1);
        chk("rq_addr", remote_addr, 16'h8200);
        reset = 1'b1; settle();
        chk("rq_async_wren", remote_wren, 0);
        chk("rq_async_empty", wbuf_empty, 1);
        tick();
        reset = 1'b0; remote_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rq_no_wren", remote_wren, 0);
            chk("rq_empty", wbuf_empty, 1);
        end
        remote_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
